pong_ball_engine: RTL and testbench

Game-physics stage of the Pong datapath. It consumes the paddle commands from the keypad scanner and the run/stop control from the top-level game FSM. It produces the ball position, both paddle positions and the per-player miss pulses. Its outputs feed the graphics generator and the scoring FSM directly.

---
 rtl/pong_ball_engine.sv | 217 +++++++++++++++++++++
 tb/tb_pong_ball_engine.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/pong_ball_engine.sv
// Pong ball/paddle physics: registered ball position, paddle positions and miss pulses,
// all advanced on the one-cycle tick strobe.
module pong_ball_engine #(
    parameter int H_RES       = 640,
    parameter int V_RES       = 480,
    parameter int BALL_SIZE   = 8,
    parameter int PADDLE_H    = 80,
    parameter int PADDLE_W    = 10,
    parameter int PADDLE_X1   = 20,
    parameter int PADDLE_X2   = 610,
    parameter int PADDLE_STEP = 4,
    parameter int SPEED_BASE  = 2,
    parameter int SPEED_MAX   = 6,
    parameter int MIN_START   = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       stop,
    input  logic       up1,
    input  logic       down1,
    input  logic       up2,
    input  logic       down2,
    input  logic [3:0] min,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic [9:0] paddle1_q,
    output logic [9:0] paddle2_q,
    output logic       miss1,
    output logic       miss2
);

    localparam logic [10:0] CX      = 11'((H_RES - BALL_SIZE) / 2);
    localparam logic [10:0] CY      = 11'((V_RES - BALL_SIZE) / 2);
    localparam logic [10:0] X_MAX   = 11'(H_RES - BALL_SIZE);
    localparam logic [10:0] Y_MAX   = 11'(V_RES - BALL_SIZE);
    localparam logic [10:0] B_SIZE  = 11'(BALL_SIZE);
    localparam logic [10:0] P_H     = 11'(PADDLE_H);
    localparam logic [10:0] P_MAX   = 11'(V_RES - PADDLE_H);
    localparam logic [10:0] P_RST   = 11'((V_RES - PADDLE_H) / 2);
    localparam logic [10:0] P_STEP  = 11'(PADDLE_STEP);
    localparam logic [10:0] P1_FACE = 11'(PADDLE_X1 + PADDLE_W);
    localparam logic [10:0] P2_FACE = 11'(PADDLE_X2);
    localparam logic [10:0] P2_STOP = 11'(PADDLE_X2 - BALL_SIZE);
    localparam logic [10:0] S_BASE  = 11'(SPEED_BASE);
    localparam logic [10:0] S_MAX   = 11'(SPEED_MAX);
    localparam logic [10:0] M_START = 11'(MIN_START);

    typedef enum logic [1:0] {SERVE, MOVE, MISS} state_e;

    state_e      state_q, state_d;
    logic [9:0]  x_q, x_d, y_q, y_d;
    logic [9:0]  p1_q, p1_d, p2_q, p2_d;
    logic        dirx_q, dirx_d;   // 1 = right
    logic        diry_q, diry_d;   // 1 = down
    logic        miss1_q, miss1_d, miss2_q, miss2_d;

    logic [10:0] min_w, spd_raw, spd;
    logic [10:0] wx, wy, wp1, wp2, nx, ny;
    logic        ndx, ndy, ov1, ov2, hit1, hit2, m1, m2, move_en;

    function automatic logic [9:0] paddle_next(input logic [9:0] p, input logic up, input logic dn);
        logic [10:0] w;
        w = {1'b0, p};
        if (up && !dn)
            w = (w >= P_STEP) ? w - P_STEP : 11'd0;
        else if (dn && !up)
            w = (w + P_STEP > P_MAX) ? P_MAX : w + P_STEP;
        return 10'(w);
    endfunction

    // Speed ramps up as the clock runs down; minutes above the start value never slow it.
    always_comb begin
        min_w   = {7'd0, min};
        spd_raw = (min_w >= M_START) ? S_BASE : S_BASE + (M_START - min_w);
        spd     = (spd_raw > S_MAX) ? S_MAX : spd_raw;
    end

    assign move_en = (state_q == MOVE) && tick && !stop;

    // Candidate ball step from the current position, evaluated every cycle.
    always_comb begin
        wx   = {1'b0, x_q};
        wy   = {1'b0, y_q};
        wp1  = {1'b0, p1_q};
        wp2  = {1'b0, p2_q};
        nx   = wx;
        ny   = wy;
        ndx  = dirx_q;
        ndy  = diry_q;
        m1   = 1'b0;
        m2   = 1'b0;
        ov1  = (wy + B_SIZE > wp1) && (wy < wp1 + P_H);
        ov2  = (wy + B_SIZE > wp2) && (wy < wp2 + P_H);
        hit1 = 1'b0;
        hit2 = 1'b0;

        if (!diry_q) begin
            if (wy < spd) begin
                ny  = 11'd0;
                ndy = 1'b1;
            end else begin
                ny = wy - spd;
            end
        end else begin
            if (wy + spd >= Y_MAX) begin
                ny  = Y_MAX;
                ndy = 1'b0;
            end else begin
                ny = wy + spd;
            end
        end

        if (!dirx_q) begin
            hit1 = (wx >= P1_FACE) && (wx - spd < P1_FACE) && ov1;
            if (hit1) begin
                nx  = P1_FACE;
                ndx = 1'b1;
            end else if (wx < spd) begin
                m1 = 1'b1;
            end else begin
                nx = wx - spd;
            end
        end else begin
            hit2 = (wx + B_SIZE <= P2_FACE) && (wx + spd + B_SIZE > P2_FACE) && ov2;
            if (hit2) begin
                nx  = P2_STOP;
                ndx = 1'b0;
            end else if (wx + spd >= X_MAX) begin
                m2 = 1'b1;
            end else begin
                nx = wx + spd;
            end
        end

        // A miss re-centres the ball and serves toward the player who missed.
        if (m1 || m2) begin
            nx  = CX;
            ny  = CY;
            ndx = m2;
            ndy = diry_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= SERVE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            SERVE:   if (tick && !stop)         state_d = MOVE;
            MOVE:    if (move_en && (m1 || m2)) state_d = MISS;
            MISS:    if (stop)                  state_d = SERVE;
            default:                            state_d = SERVE;
        endcase
    end

    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        dirx_d  = dirx_q;
        diry_d  = diry_q;
        p1_d    = p1_q;
        p2_d    = p2_q;
        miss1_d = 1'b0;
        miss2_d = 1'b0;

        if (state_q != MOVE) begin
            x_d = 10'(CX);
            y_d = 10'(CY);
        end else if (move_en) begin
            x_d     = 10'(nx);
            y_d     = 10'(ny);
            dirx_d  = ndx;
            diry_d  = ndy;
            miss1_d = m1;
            miss2_d = m2;
        end

        if (tick) begin
            p1_d = paddle_next(p1_q, up1, down1);
            p2_d = paddle_next(p2_q, up2, down2);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_q     <= 10'(CX);
            y_q     <= 10'(CY);
            dirx_q  <= 1'b1;
            diry_q  <= 1'b1;
            p1_q    <= 10'(P_RST);
            p2_q    <= 10'(P_RST);
            miss1_q <= 1'b0;
            miss2_q <= 1'b0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            dirx_q  <= dirx_d;
            diry_q  <= diry_d;
            p1_q    <= p1_d;
            p2_q    <= p2_d;
            miss1_q <= miss1_d;
            miss2_q <= miss2_d;
        end
    end

    assign ball_x    = x_q;
    assign ball_y    = y_q;
    assign paddle1_q = p1_q;
    assign paddle2_q = p2_q;
    assign miss1     = miss1_q;
    assign miss2     = miss2_q;

endmodule

// File: tb/tb_pong_ball_engine.sv
// Directed bench for pong_ball_engine: paddle/speed vector tables plus hand-traced
// ball flights through wall bounces, paddle hits, misses and a mid-flight reset.
module tb_pong_ball_engine;

    logic       clk = 1'b0, rst = 1'b1, tick = 1'b0, stop = 1'b1;
    logic       up1 = 1'b0, down1 = 1'b0, up2 = 1'b0, down2 = 1'b0;
    logic [3:0] min = 4'd3;
    logic [9:0] ball_x, ball_y, paddle1_q, paddle2_q;
    logic       miss1, miss2;

    int checks = 0;
    int errors = 0;

    pong_ball_engine dut (
        .clk(clk), .rst(rst), .tick(tick), .stop(stop),
        .up1(up1), .down1(down1), .up2(up2), .down2(down2), .min(min),
        .ball_x(ball_x), .ball_y(ball_y), .paddle1_q(paddle1_q), .paddle2_q(paddle2_q),
        .miss1(miss1), .miss2(miss2)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic u1, d1, u2, d2;
        int   e1, e2;
    } pad_vec_t;

    typedef struct {
        logic [3:0] mn;
        int         ex, ey;
    } spd_vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic ball(input string nm, input int ex, input int ey);
        chk({nm, ".x"}, {22'd0, ball_x}, ex);
        chk({nm, ".y"}, {22'd0, ball_y}, ey);
    endtask

    // Called at a negedge; one tick edge, then back to the next negedge for sampling.
    task automatic tk();
        tick = 1'b1;
        @(posedge clk);
        #1 tick = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        pad_vec_t pv[7];
        spd_vec_t sv[7];
        logic     saw;

        pv[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 196, 200};
        pv[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 196, 204};
        pv[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 196, 200};
        pv[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 200, 204};
        pv[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 200, 204};
        pv[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 200, 204};
        pv[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 196, 204};

        sv[0] = '{4'd3,  318, 238};
        sv[1] = '{4'd1,  322, 242};
        sv[2] = '{4'd0,  327, 247};
        sv[3] = '{4'd9,  329, 249};
        sv[4] = '{4'd2,  332, 252};
        sv[5] = '{4'd15, 334, 254};
        sv[6] = '{4'd4,  336, 256};

        // Reset state
        #1 rst = 1'b0;
        #2;
        ball("rst", 316, 236);
        chk("rst.p1", {22'd0, paddle1_q}, 200);
        chk("rst.p2", {22'd0, paddle2_q}, 200);
        chk("rst.miss1", {31'd0, miss1}, 0);
        chk("rst.miss2", {31'd0, miss2}, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        repeat (10) tk();
        ball("serve_hold", 316, 236);

        // Paddle command table (ball parked in SERVE)
        for (int i = 0; i < 7; i++) begin
            up1 = pv[i].u1; down1 = pv[i].d1; up2 = pv[i].u2; down2 = pv[i].d2;
            tk();
            chk($sformatf("padvec%0d.p1", i), {22'd0, paddle1_q}, pv[i].e1);
            chk($sformatf("padvec%0d.p2", i), {22'd0, paddle2_q}, pv[i].e2);
        end
        up1 = 1'b1; down1 = 1'b0; up2 = 1'b0; down2 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("notick.p1", {22'd0, paddle1_q}, 196);
        repeat (60) tk();
        chk("p1_floor", {22'd0, paddle1_q}, 0);
        up1 = 1'b0; down2 = 1'b1;
        repeat (60) tk();
        chk("p2_ceil", {22'd0, paddle2_q}, 400);
        down2 = 1'b0;
        ball("paddles_serve", 316, 236);

        // Serve right/down, bounce off bottom wall, hit paddle 2 (at 400)
        stop = 1'b0;
        tk();
        ball("serve_to_move", 316, 236);
        saw = 1'b0;
        for (int k = 1; k <= 145; k++) begin
            tk();
            saw |= miss1 | miss2;
            if (k == 117) ball("bot_pre", 550, 470);
            if (k == 118) ball("bot_hit", 552, 472);
            if (k == 119) ball("bot_after", 554, 470);
            if (k == 143) ball("p2_reach", 602, 422);
            if (k == 144) ball("p2_hit", 602, 420);
            if (k == 145) ball("p2_bounce", 600, 418);
        end
        chk("nomiss_flight1", {31'd0, saw}, 0);

        stop = 1'b1;
        tk();
        ball("freeze", 600, 418);
        stop = 1'b0;

        // Left/up to top wall, past paddle 1 (at 0) and out the left edge
        saw = 1'b0;
        for (int j = 1; j <= 300; j++) begin
            tk();
            saw |= miss1 | miss2;
            if (j == 210) ball("top_hit", 180, 0);
            if (j == 211) ball("top_after", 178, 2);
            if (j == 286) ball("p1_pass", 28, 152);
            if (j == 300) ball("left_edge", 0, 180);
        end
        chk("nomiss_flight2", {31'd0, saw}, 0);
        tk();
        chk("miss1_pulse", {31'd0, miss1}, 1);
        chk("miss1_only", {31'd0, miss2}, 0);
        ball("miss1_centre", 316, 236);
        @(negedge clk);
        chk("miss1_clear", {31'd0, miss1}, 0);
        tk();
        ball("miss_hold", 316, 236);

        // Re-serve toward player 1; raise paddle 1 to 400 while flying, expect a hit
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        tk();
        ball("reserve_left", 316, 236);
        saw = 1'b0;
        for (int k = 1; k <= 145; k++) begin
            down1 = (k <= 100);
            tk();
            saw |= miss1 | miss2;
            if (k == 100) chk("p1_raise", {22'd0, paddle1_q}, 400);
            if (k == 143) ball("p1_reach", 30, 422);
            if (k == 144) ball("p1_hit", 30, 420);
            if (k == 145) ball("p1_bounce", 32, 418);
        end
        down1 = 1'b0;
        chk("nomiss_flight3", {31'd0, saw}, 0);

        // Drop paddle 2 to 0, ball passes it and exits the right edge
        saw = 1'b0;
        for (int m = 1; m <= 299; m++) begin
            up2 = (m <= 100);
            tk();
            saw |= miss1 | miss2;
            if (m == 100) chk("p2_drop", {22'd0, paddle2_q}, 0);
            if (m == 209) ball("top2_reach", 450, 0);
            if (m == 210) ball("top2_hit", 452, 0);
            if (m == 285) ball("p2_face", 602, 150);
            if (m == 286) ball("p2_pass", 604, 152);
            if (m == 299) ball("right_edge", 630, 178);
        end
        up2 = 1'b0;
        chk("nomiss_flight4", {31'd0, saw}, 0);
        tk();
        chk("miss2_pulse", {31'd0, miss2}, 1);
        chk("miss2_only", {31'd0, miss1}, 0);
        ball("miss2_centre", 316, 236);
        @(negedge clk);
        chk("miss2_clear", {31'd0, miss2}, 0);

        // Serve right again and sweep the speed table
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        tk();
        ball("reserve_right", 316, 236);
        for (int i = 0; i < 7; i++) begin
            min = sv[i].mn;
            tk();
            ball($sformatf("spd_min%0d", sv[i].mn), sv[i].ex, sv[i].ey);
        end
        min = 4'd3;

        // Asynchronous reset in the middle of a clock period
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        ball("async_rst", 316, 236);
        chk("async_rst.p1", {22'd0, paddle1_q}, 200);
        chk("async_rst.p2", {22'd0, paddle2_q}, 200);
        chk("async_rst.miss", {30'd0, miss1, miss2}, 0);
        @(negedge clk);
        rst = 1'b1;
        stop = 1'b1;
        tk();
        ball("post_rst", 316, 236);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
